// File: rtl/dec_echo_scheduler.sv
// ---------------------------------------------------------------------------
// dec_echo_scheduler
//
// Sits between a UART receiver and a UART transmitter. Received bytes wait in
// a small FIFO. One at a time they are handed to an external byte-to-decimal
// ASCII converter. The three result digits and a separator character are then
// streamed to the transmitter over a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_data      received byte, qualified by the one-cycle strobe rx_done
//   conv_byte    byte presented to the converter (held while converting)
//   conv_valid   one-cycle conversion request
//   conv_dec     converter result {hundreds, tens, units} as ASCII
//   tx_data      character to transmit, qualified by tx_valid
//   tx_ready     transmitter accepts (transfer when tx_valid & tx_ready)
//   busy         scheduler is not idle
//   ovf_pulse    one-cycle pulse after a byte was dropped on a full FIFO
//   drop_cnt     saturating count of dropped bytes
//   fifo_level   current FIFO occupancy
// ---------------------------------------------------------------------------
module dec_echo_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CONV_LAT    = 2,
    parameter logic [7:0]  SEP_CHAR    = 8'h20,
    parameter bit          LZ_SUPPRESS = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    output logic [7:0]                    conv_byte,
    output logic                          conv_valid,
    input  logic [23:0]                   conv_dec,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          ovf_pulse,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]  LAT_LAST = 3'(CONV_LAT - 1);
    localparam logic [7:0]  ZERO_CH  = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND_H,
        SEND_T,
        SEND_U,
        SEND_SEP
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop, drop;

    logic [2:0]    conv_cnt;
    logic [23:0]   digit;
    logic          conv_done;
    logic [7:0]    dig_h, dig_t, dig_u;

    assign full  = (fifo_level == FULL_LVL);
    assign empty = (fifo_level == '0);

    // The scheduler only ever pops from IDLE, and only when something is
    // queued, so a push into an empty FIFO can never be popped in the same
    // cycle. A pop frees a slot, which lets a push land on a full FIFO.
    assign pop  = (state == IDLE) && !empty;
    assign push = rx_done && (!full || pop);
    assign drop = rx_done && full && !pop;

    assign dig_h = digit[23:16];
    assign dig_t = digit[15:8];
    assign dig_u = digit[7:0];

    // The first CONV edge is the one that samples conv_valid; latency edges
    // are counted from there, so the counter only advances once conv_valid
    // has dropped.
    assign conv_done = (state == CONV) && !conv_valid && (conv_cnt == LAT_LAST);

    assign busy = (state != IDLE);

    // Storage has no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf_pulse  <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            ovf_pulse <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Conversion request, latency counter and captured digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_byte  <= 8'd0;
            conv_valid <= 1'b0;
            conv_cnt   <= 3'd0;
            digit      <= 24'd0;
        end else begin
            if (pop) begin
                conv_byte  <= mem[rd_ptr];
                conv_valid <= 1'b1;
                conv_cnt   <= 3'd0;
            end else begin
                conv_valid <= 1'b0;
                if ((state == CONV) && !conv_valid) begin
                    conv_cnt <= conv_cnt + 3'd1;
                end
            end
            if (conv_done) begin
                digit <= conv_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Send states present a character and hold it until the transmitter
    // takes it. Suppressed leading zeros spend one cycle with tx_valid low.
    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_nx = SEND_H;
                end
            end
            SEND_H: begin
                if (LZ_SUPPRESS && (dig_h == ZERO_CH)) begin
                    state_nx = SEND_T;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = dig_h;
                    if (tx_ready) begin
                        state_nx = SEND_T;
                    end
                end
            end
            SEND_T: begin
                if (LZ_SUPPRESS && (dig_h == ZERO_CH) && (dig_t == ZERO_CH)) begin
                    state_nx = SEND_U;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = dig_t;
                    if (tx_ready) begin
                        state_nx = SEND_U;
                    end
                end
            end
            SEND_U: begin
                tx_valid = 1'b1;
                tx_data  = dig_u;
                if (tx_ready) begin
                    state_nx = SEND_SEP;
                end
            end
            SEND_SEP: begin
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (tx_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dec_echo_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dec_echo_scheduler
//
// Drives two scheduler instances with identical stimulus, one with leading
// zero suppression off and one with it on. Each instance has its own
// converter model and its own expected character and conversion queues,
// derived from the decimal value of every accepted byte.
// ---------------------------------------------------------------------------
module tb_dec_echo_scheduler;

    localparam int          CONV_LAT = 2;
    localparam logic [7:0]  SEP      = 8'h20;
    localparam logic [23:0] GARBAGE  = 24'h3F3F3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_ready;

    logic [7:0]  conv_byte_v  [2];
    logic        conv_valid_v [2];
    logic [23:0] conv_dec_v   [2];
    logic [7:0]  tx_data_v    [2];
    logic        tx_valid_v   [2];
    logic        busy_v       [2];
    logic        ovf_pulse_v  [2];
    logic [7:0]  drop_cnt_v   [2];
    logic [2:0]  fifo_level_v [2];

    int n_vec = 0;
    int n_err = 0;
    bit rnd_ready = 1'b0;

    logic [7:0] txq0 [$];
    logic [7:0] txq1 [$];
    logic [7:0] cvq0 [$];
    logic [7:0] cvq1 [$];

    bit          prev_stall [2];
    logic [7:0]  prev_data  [2];
    bit          prev_cv    [2];

    logic [23:0] cm_val [2];
    int          cm_k   [2];
    bit          cm_act [2];

    always #5 clk = ~clk;

    dec_echo_scheduler #(
        .FIFO_DEPTH(4), .CONV_LAT(CONV_LAT), .SEP_CHAR(SEP), .LZ_SUPPRESS(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .conv_byte(conv_byte_v[0]), .conv_valid(conv_valid_v[0]),
        .conv_dec(conv_dec_v[0]), .tx_data(tx_data_v[0]),
        .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready), .busy(busy_v[0]),
        .ovf_pulse(ovf_pulse_v[0]), .drop_cnt(drop_cnt_v[0]),
        .fifo_level(fifo_level_v[0])
    );

    dec_echo_scheduler #(
        .FIFO_DEPTH(4), .CONV_LAT(CONV_LAT), .SEP_CHAR(SEP), .LZ_SUPPRESS(1'b1)
    ) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .conv_byte(conv_byte_v[1]), .conv_valid(conv_valid_v[1]),
        .conv_dec(conv_dec_v[1]), .tx_data(tx_data_v[1]),
        .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready), .busy(busy_v[1]),
        .ovf_pulse(ovf_pulse_v[1]), .drop_cnt(drop_cnt_v[1]),
        .fifo_level(fifo_level_v[1])
    );

    function automatic logic [23:0] toDec(input logic [7:0] b);
        int v;
        v = int'(b);
        return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the characters each instance is expected to send for byte b.
    task automatic pushExpected(input logic [7:0] b);
        int h, t, u;
        h = int'(b) / 100;
        t = (int'(b) / 10) % 10;
        u = int'(b) % 10;
        txq0.push_back(8'(48 + h));
        txq0.push_back(8'(48 + t));
        txq0.push_back(8'(48 + u));
        txq0.push_back(SEP);
        if (h != 0) txq1.push_back(8'(48 + h));
        if (h != 0 || t != 0) txq1.push_back(8'(48 + t));
        txq1.push_back(8'(48 + u));
        txq1.push_back(SEP);
        cvq0.push_back(b);
        cvq1.push_back(b);
    endtask

    // Converter model: result valid only in the cycle before the edge that
    // lies CONV_LAT edges after the edge sampling conv_valid.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                cm_act[i] = 1'b0;
                cm_k[i]   = 0;
                conv_dec_v[i] <= GARBAGE;
            end else begin
                if (conv_valid_v[i]) begin
                    cm_val[i] = toDec(conv_byte_v[i]);
                    cm_k[i]   = 0;
                    cm_act[i] = 1'b1;
                end else if (cm_act[i]) begin
                    cm_k[i]++;
                end
                if (cm_act[i] && cm_k[i] == CONV_LAT - 1) begin
                    conv_dec_v[i] <= cm_val[i];
                end else begin
                    conv_dec_v[i] <= GARBAGE;
                    if (cm_k[i] > CONV_LAT - 1) cm_act[i] = 1'b0;
                end
            end
        end
    end

    task automatic monitorInst(input int i);
        logic [7:0] e;
        bit         have;
        if (!rst_n) begin
            prev_stall[i] = 1'b0;
            prev_cv[i]    = 1'b0;
            return;
        end
        if (prev_stall[i]) begin
            checkOutput($sformatf("stall_hold[%0d]", i),
                        {23'd0, tx_valid_v[i], tx_data_v[i]},
                        {23'd0, 1'b1, prev_data[i]});
        end
        if (tx_valid_v[i] && tx_ready) begin
            have = (i == 0) ? (txq0.size() > 0) : (txq1.size() > 0);
            if (have) begin
                e = (i == 0) ? txq0.pop_front() : txq1.pop_front();
                checkOutput($sformatf("tx_char[%0d]", i), {24'd0, tx_data_v[i]}, {24'd0, e});
            end else begin
                checkOutput($sformatf("tx_unexpected[%0d]", i),
                            {23'd0, tx_valid_v[i], tx_data_v[i]}, 32'd0);
            end
        end
        if (conv_valid_v[i]) begin
            checkOutput($sformatf("conv_one_cycle[%0d]", i), {31'd0, prev_cv[i]}, 32'd0);
            have = (i == 0) ? (cvq0.size() > 0) : (cvq1.size() > 0);
            if (have) begin
                e = (i == 0) ? cvq0.pop_front() : cvq1.pop_front();
                checkOutput($sformatf("conv_byte[%0d]", i), {24'd0, conv_byte_v[i]}, {24'd0, e});
            end else begin
                checkOutput($sformatf("conv_unexpected[%0d]", i),
                            {23'd0, conv_valid_v[i], conv_byte_v[i]}, 32'd0);
            end
        end
        prev_stall[i] = tx_valid_v[i] && !tx_ready;
        prev_data[i]  = tx_data_v[i];
        prev_cv[i]    = conv_valid_v[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitorInst(i);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit exp_drop);
        rx_data = b;
        rx_done = 1'b1;
        if (!exp_drop) pushExpected(b);
        tick();
        rx_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("ovf_pulse[%0d]", i), {31'd0, ovf_pulse_v[i]}, {31'd0, exp_drop});
        end
    endtask

    task automatic waitDrain(input int budget);
        int c;
        c = 0;
        while (c < budget && !(txq0.size() == 0 && txq1.size() == 0 &&
                               !busy_v[0] && !busy_v[1] &&
                               fifo_level_v[0] == 3'd0 && fifo_level_v[1] == 3'd0)) begin
            tick();
            c++;
        end
        checkOutput("drain_done", {31'd0, c < budget}, 32'd1);
    endtask

    task automatic checkDrops(input logic [7:0] exp);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("drop_cnt[%0d]", i), {24'd0, drop_cnt_v[i]}, {24'd0, exp});
        end
    endtask

    initial begin
        int c;
        logic [7:0] b;
        rst_n    = 1'b0;
        rx_data  = 8'd0;
        rx_done  = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset_outputs[%0d]", i),
                        {tx_valid_v[i], conv_valid_v[i], busy_v[i], ovf_pulse_v[i],
                         fifo_level_v[i], tx_data_v[i], conv_byte_v[i], drop_cnt_v[i]},
                        32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Single byte, transmitter always ready.
        tx_ready = 1'b1;
        applyStimulus(8'h7B, 1'b0);
        waitDrain(100);
        checkDrops(8'd0);

        // Extremes of the byte range.
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        waitDrain(100);

        // Values that exercise zero suppression.
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        applyStimulus(8'h64, 1'b0);
        waitDrain(150);

        // Random backpressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b0);
            waitDrain(300);
        end
        rnd_ready = 1'b0;

        // Overflow with the transmitter stalled.
        tx_ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            applyStimulus(8'(8'h11 * (n + 1)), n >= 5);
            tick();
            tick();
        end
        checkOutput("ovf_level", {29'd0, fifo_level_v[0]}, 32'd4);
        checkOutput("ovf_level_lz", {29'd0, fifo_level_v[1]}, 32'd4);
        checkDrops(8'd2);
        tx_ready = 1'b1;
        waitDrain(300);
        checkDrops(8'd2);

        // Random bursts that never exceed one in flight plus a full FIFO.
        rnd_ready = 1'b1;
        for (int burst = 0; burst < 6; burst++) begin
            c = $urandom_range(1, 5);
            for (int n = 0; n < c; n++) begin
                if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 15));
                else b = 8'($urandom_range(0, 255));
                applyStimulus(b, 1'b0);
                repeat ($urandom_range(0, 3)) tick();
            end
            waitDrain(600);
        end
        rnd_ready = 1'b0;

        // Reset while the tens digit is waiting and three bytes are queued.
        tx_ready = 1'b0;
        applyStimulus(8'hC8, 1'b0);
        for (int n = 0; n < 3; n++) applyStimulus(8'($urandom_range(0, 255)), 1'b0);
        c = 0;
        while (c < 30 && !tx_valid_v[0]) begin
            tick();
            c++;
        end
        checkOutput("reach_send_h", {31'd0, tx_valid_v[0]}, 32'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checkOutput("pre_reset_level", {29'd0, fifo_level_v[0]}, 32'd3);
        checkOutput("pre_reset_tx", {23'd0, tx_valid_v[0], tx_data_v[0]}, {23'd0, 1'b1, 8'h30});
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("abort_state[%0d]", i),
                        {26'd0, tx_valid_v[i], busy_v[i], conv_valid_v[i], fifo_level_v[i]},
                        32'd0);
        end
        checkDrops(8'd0);
        txq0.delete();
        txq1.delete();
        cvq0.delete();
        cvq1.delete();
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (15) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("post_reset_idle[%0d]", i),
                        {27'd0, tx_valid_v[i], busy_v[i], fifo_level_v[i]}, 32'd0);
        end
        applyStimulus(8'h2A, 1'b0);
        waitDrain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
